// File: rtl/apb_regbank_pkg.sv
// Shared register map, field positions and status layout for the APB register bank.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package apb_regbank_pkg;

  // Register byte addresses
  localparam logic [4:0] ADDR_ID        = 5'h00;
  localparam logic [4:0] ADDR_CTRL      = 5'h01;
  localparam logic [4:0] ADDR_GPIO_OUT  = 5'h02;
  localparam logic [4:0] ADDR_GPIO_IN   = 5'h03;
  localparam logic [4:0] ADDR_FIFO_DATA = 5'h04;
  localparam logic [4:0] ADDR_FIFO_STAT = 5'h05;
  localparam logic [4:0] ADDR_XFER_CNT  = 5'h06;

  // SCRATCH window is 0x10-0x1F: bit 4 selects it, bits [3:0] index the array
  localparam int SCRATCH_SEL_BIT = 4;
  localparam int SCRATCH_IDX_W   = 4;
  localparam int SCRATCH_DEPTH   = 16;

  // Field positions
  localparam int CTRL_WAIT_W  = 2;
  localparam int STAT_OVF_BIT = 5;
  localparam int STAT_UNF_BIT = 6;

  localparam logic [7:0] ID_DEFAULT = 8'hB8;

  // FIFO_STAT register image
  typedef struct packed {
    logic       rsvd;
    logic       underflow;
    logic       overflow;
    logic       full;
    logic       empty;
    logic [2:0] count;
  } fifo_stat_t;

endpackage

// File: rtl/regbank_fifo.sv
// Small synchronous FIFO: push/pop with full/empty/count; head entry visible on pop_dat.
// Latency: a pushed entry is visible at the head one edge after the push.
// Backpressure: push when full is dropped, pop when empty is ignored; caller flags these.
//
// Ports: clk, rst_n (async active-low), push_vld/push_dat, pop_vld/pop_dat (head),
//        full, empty, count.
module regbank_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_vld,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign pop_dat = mem[rd_ptr];
  assign do_push = push_vld && !full;
  assign do_pop  = pop_vld && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/apb_regbank.sv
// APB slave register bank: ID, CTRL (wait states), GPIO, data FIFO + status, transfer counter, scratch RAM.
// Latency: completes after CTRL.WAIT wait cycles; writes take effect on the completion edge.
// Backpressure: PREADY held low for CTRL.WAIT access cycles; no other stall source.
//
// Ports: PCLK, PRESETn (async active-low), APB slave (PSEL, PADDR, PENABLE, PWRITE, PWDATA,
//        PRDATA, PREADY), gpio_in (async, synchronized), gpio_out (registered).
module apb_regbank
  import apb_regbank_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] ID_VALUE   = ID_DEFAULT
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       PSEL,
  input  logic [4:0] PADDR,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  input  logic [7:0] gpio_in,
  output logic [7:0] gpio_out
);

  logic                   access;
  logic                   complete;
  logic                   wr_en;
  logic                   rd_en;
  logic [1:0]             wait_cnt;
  logic [CTRL_WAIT_W-1:0] ctrl_wait;
  logic [7:0]             gpio_out_q;
  logic [7:0]             gpio_meta;
  logic [7:0]             gpio_sync;
  logic [7:0]             xfer_cnt;
  logic                   ovf;
  logic                   unf;
  logic [7:0]             scratch [SCRATCH_DEPTH];
  logic [7:0]             rdata;

  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   stat_wr;
  logic [7:0]             fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [2:0]             fifo_count;
  fifo_stat_t             stat;

  // ---------------- APB handshake ----------------
  // Wait counter only advances while stalled, so a transfer completes once it reaches WAIT.
  // CTRL only changes on a completion edge, so a new WAIT naturally applies from the next transfer.
  assign access   = PSEL && PENABLE;
  assign PREADY   = !access || (wait_cnt == ctrl_wait);
  assign complete = access && PREADY;
  assign wr_en    = complete && PWRITE;
  assign rd_en    = complete && !PWRITE;

  // Dropping PSEL mid-wait lands in the non-access branch: counter clears, nothing committed.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                wait_cnt <= '0;
    else if (!access || PREADY)  wait_cnt <= '0;
    else                         wait_cnt <= wait_cnt + 2'd1;
  end

  // ---------------- decoded side-effect strobes ----------------
  assign fifo_push = wr_en && !PADDR[SCRATCH_SEL_BIT] && (PADDR == ADDR_FIFO_DATA);
  assign fifo_pop  = rd_en && !PADDR[SCRATCH_SEL_BIT] && (PADDR == ADDR_FIFO_DATA);
  assign stat_wr   = wr_en && (PADDR == ADDR_FIFO_STAT);

  regbank_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk      (PCLK),
    .rst_n    (PRESETn),
    .push_vld (fifo_push),
    .push_dat (PWDATA),
    .pop_vld  (fifo_pop),
    .pop_dat  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // ---------------- control / status registers ----------------
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ctrl_wait  <= '0;
      gpio_out_q <= '0;
      xfer_cnt   <= '0;
      ovf        <= 1'b0;
      unf        <= 1'b0;
    end else begin
      if (wr_en && (PADDR == ADDR_CTRL))     ctrl_wait  <= PWDATA[CTRL_WAIT_W-1:0];
      if (wr_en && (PADDR == ADDR_GPIO_OUT)) gpio_out_q <= PWDATA;
      if (complete)                          xfer_cnt   <= xfer_cnt + 8'd1;
      // Sticky flags: write-1 clears, but a same-edge event re-sets (set wins).
      ovf <= (ovf && !(stat_wr && PWDATA[STAT_OVF_BIT])) || (fifo_push && fifo_full);
      unf <= (unf && !(stat_wr && PWDATA[STAT_UNF_BIT])) || (fifo_pop && fifo_empty);
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < SCRATCH_DEPTH; i++) scratch[i] <= '0;
    end else if (wr_en && PADDR[SCRATCH_SEL_BIT]) begin
      scratch[PADDR[SCRATCH_IDX_W-1:0]] <= PWDATA;
    end
  end

  // Two-flop synchronizer for the asynchronous GPIO inputs
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      gpio_meta <= '0;
      gpio_sync <= '0;
    end else begin
      gpio_meta <= gpio_in;
      gpio_sync <= gpio_meta;
    end
  end

  assign gpio_out = gpio_out_q;

  // ---------------- read path ----------------
  assign stat = '{rsvd:      1'b0,
                  underflow: unf,
                  overflow:  ovf,
                  full:      fifo_full,
                  empty:     fifo_empty,
                  count:     fifo_count};

  always_comb begin
    rdata = 8'h00;
    if (PADDR[SCRATCH_SEL_BIT]) begin
      rdata = scratch[PADDR[SCRATCH_IDX_W-1:0]];
    end else begin
      case (PADDR)
        ADDR_ID:        rdata = ID_VALUE;
        ADDR_CTRL:      rdata = {{(8-CTRL_WAIT_W){1'b0}}, ctrl_wait};
        ADDR_GPIO_OUT:  rdata = gpio_out_q;
        ADDR_GPIO_IN:   rdata = gpio_sync;
        ADDR_FIFO_DATA: rdata = fifo_empty ? 8'h00 : fifo_head;
        ADDR_FIFO_STAT: rdata = stat;
        ADDR_XFER_CNT:  rdata = xfer_cnt; // pre-increment value
        default:        rdata = 8'h00;
      endcase
    end
  end

  assign PRDATA = rd_en ? rdata : 8'h00;

endmodule

// File: doc/apb_regbank.md
APB_REGBANK -- requirements
Module: apb_regbank

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, depth of the data FIFO; the design SHALL support only 4.
REQ-002 Parameter ID_VALUE, default 8'hB8, constant returned by the ID register.
REQ-003 PCLK  in  1  sole clock; all state SHALL update on the rising edge.
REQ-004 PRESETn  in  1  asynchronous active-low reset.
REQ-005 PSEL  in  1  APB select.
REQ-006 PADDR  in  5  APB byte address.
REQ-007 PENABLE  in  1  APB access phase.
REQ-008 PWRITE  in  1  1=write, 0=read.
REQ-009 PWDATA  in  8  write data.
REQ-010 PRDATA  out  8  read data.
REQ-011 PREADY  out  1  transfer completion, with wait states.
REQ-012 gpio_in  in  8  asynchronous external inputs.
REQ-013 gpio_out  out  8  registered GPIO_OUT value.

Function
REQ-014 Access cycle: PSEL=1 and PENABLE=1; completion cycle: access cycle with PREADY=1.
REQ-015 PREADY SHALL be 1 outside access cycles, and in an access cycle 1 exactly when wait counter equals CTRL.WAIT[1:0].
- Wait counter: 2 bits; cleared at reset and in every non-access cycle; increments in each access cycle where PREADY=0.
- WAIT=0 gives zero-wait completion in the first access cycle.
REQ-016 All side effects (register write, FIFO push/pop, flag set/clear, XFER_CNT increment) SHALL occur exactly once, on the completion-cycle edge.
REQ-017 PRDATA SHALL be the addressed register value in read completion cycles and 8'h00 in all other cycles.
REQ-018 Register map:
- 0x00 ID: RO, ID_VALUE.
- 0x01 CTRL: RW, bits [1:0] WAIT; others read 0. New WAIT applies from the next transfer.
- 0x02 GPIO_OUT: RW, drives gpio_out.
- 0x03 GPIO_IN: RO, gpio_in after a two-flop synchronizer.
- 0x04 FIFO_DATA: write pushes, read pops.
- 0x05 FIFO_STAT: [2:0] count, [3] empty, [4] full, [5] overflow (sticky), [6] underflow (sticky). Writing 1 to bit 5 or 6 clears that bit.
- 0x06 XFER_CNT: RO, count of completed transfers; 8-bit, wraps 0xFF->0x00. A read returns the pre-increment value.
- 0x10-0x1F SCRATCH: 16x8 RW array, indexed by PADDR[3:0].
- All other addresses: read 8'h00, writes ignored.
REQ-019 FIFO push when full: data SHALL be dropped, count unchanged, overflow set.
REQ-020 FIFO pop when empty: read SHALL return 8'h00, count unchanged, underflow set.
REQ-021 FIFO_DATA read returns the head entry; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-022 A write-1-clear and a new flag event on the same edge: set SHALL win.
REQ-023 PSEL deasserted mid-wait (protocol violation): the counter SHALL clear and no side effect SHALL occur.

Reset
REQ-024 On PRESETn low, the following SHALL clear asynchronously to 0:
- CTRL, GPIO_OUT, synchronizer flops, FIFO pointers/count/flags, XFER_CNT, wait counter.
- The block SHALL then present empty=1, PREADY=1, PRDATA=8'h00, gpio_out=8'h00.
REQ-025 SCRATCH SHALL reset to 8'h00.
REQ-026 Reset asserted mid-transfer SHALL abort it with no side effect; the next transfer starts clean.

Structure
REQ-027 Package apb_regbank_pkg SHALL hold register address constants, field bit positions and the default ID value.
REQ-028 The FIFO SHALL be a sub-module regbank_fifo: push/pop/full/empty/count, same clock and reset.

Verification
REQ-029 Reset, then read 0x00 with WAIT=0 -> PREADY=1 in first access cycle, PRDATA=0xB8.
REQ-030 Write CTRL=0x03, then read 0x02 -> PREADY low for 3 access cycles, high on the 4th, PRDATA=0x00; then write CTRL=0x00 -> next transfer has zero wait.
REQ-031 Push 0x11,0x22,0x33,0x44,0x55 -> STAT=0x34 (count 4, full, overflow); pop x4 -> 0x11..0x44; 5th pop -> 0x00 and STAT=0x68 (count 0, empty, overflow, underflow); write STAT=0x60 -> STAT=0x08.
REQ-032 Write SCRATCH 0x10..0x1F with 0xA0..0xAF; read back -> exact match; read 0x07 and 0x0F -> 0x00.
REQ-033 Drive gpio_in=0x5A -> GPIO_IN reads 0x5A no earlier than 2 edges later; write GPIO_OUT=0xC3 -> gpio_out=0xC3 after the completion edge.
REQ-034 WAIT=2, assert PRESETn low during the second access cycle -> no side effect, all outputs at reset values; 256 completed transfers -> XFER_CNT wraps to the starting value.
